i_cache: RTL
============

# i_cache

Direct-mapped, read-only instruction cache between the CPU instruction port (`inst_req`/`inst_addr_ok`/`inst_data_ok` sram-like master) and the sram-like-to-AXI bridge. Serves hits in one cycle after acceptance. Refills 4-word (16-byte) lines on a miss by issuing four sequential single-word sram-like reads downstream. One request outstanding on each side at any time.

## Interface
- `INDEX_WIDTH`, 7: line index bits; 2^INDEX_WIDTH lines. Tag width = 28-INDEX_WIDTH. Offset fixed at addr[3:0]; word select is addr[3:2].
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cpu_inst_req`  in  1  CPU request valid.
- `cpu_inst_wr`  in  1  ignored; every request is treated as a read.
- `cpu_inst_size`  in  2  ignored; always a full word.
- `cpu_inst_addr`  in  32  byte address; addr[1:0] ignored.
- `cpu_inst_wdata`  in  32  ignored.
- `cpu_inst_addr_ok`  out  1  request accepted this cycle.
- `cpu_inst_data_ok`  out  1  `cpu_inst_rdata` valid this cycle.
- `cpu_inst_rdata`  out  32  instruction word.
- `cache_inst_req`  out  1  downstream request valid.
- `cache_inst_wr`  out  1  constant 0.
- `cache_inst_size`  out  2  constant 2'b10.
- `cache_inst_addr`  out  32  downstream word address.
- `cache_inst_wdata`  out  32  constant 0.
- `cache_inst_addr_ok`  in  1  downstream accepted request.
- `cache_inst_data_ok`  in  1  downstream read data valid.
- `cache_inst_rdata`  in  32  downstream read data.

## Operation
- Arrays: `valid[2^INDEX_WIDTH]`, `tag[...]`, `data[line][4]`; register arrays, combinational read. Only `valid` is reset.
- Registers: `state`, `req_addr` (latched CPU address), `cnt` (2-bit refill word counter), `resp_word`.
- IDLE: `cpu_inst_addr_ok = cpu_inst_req`. On accept, latch `req_addr` and go to LOOKUP. `addr_ok` is 0 in all other states.
- LOOKUP: hit = `valid[idx] && tag[idx]==req_addr[31:INDEX_WIDTH+4]`.
  - Hit: `cpu_inst_data_ok=1`, `rdata=data[idx][req_addr[3:2]]`, go to IDLE.
  - Miss: clear `cnt`, go to REQ.
- REQ: `cache_inst_req=1`, `cache_inst_addr={req_addr[31:4],cnt,2'b00}`. Held stable until `cache_inst_addr_ok`, then go to WAIT.
- WAIT: on `cache_inst_data_ok`:
  - Write `data[idx][cnt]`.
  - If `cnt==req_addr[3:2]`, capture the word into `resp_word`.
  - If `cnt==3`: set `valid[idx]`, write `tag[idx]`, go to RESP. Otherwise `cnt++` and go to REQ.
- If `cache_inst_data_ok` arrives in the same cycle as `cache_inst_addr_ok` in REQ, it is consumed as that word's data (same actions as WAIT) and the FSM skips WAIT.
- RESP: `cpu_inst_data_ok=1`, `rdata=resp_word`, go to IDLE.
- Refill order is always word 0..3; no critical-word-first.
- The line is marked valid only after all four words are written.
- No invalidate port. Instruction memory is never modified while cached.

## Timing
- Reset values:
  - state=IDLE, all `valid`=0, `cnt`=0.
  - All outputs 0, except `cache_inst_size`=2'b10.
- Hit: accept at T, `cpu_inst_data_ok` at T+1. Next accept possible at T+2 (throughput 1 per 2 cycles).
- Miss with zero-wait downstream (`addr_ok` same cycle as `req`, `data_ok` next cycle):
  - Requests at T+2, T+4, T+6, T+8.
  - Data at T+3, T+5, T+7, T+9.
  - `cpu_inst_data_ok` at T+10.
- `cpu_inst_data_ok` is a single-cycle pulse, exactly one per accepted request.
- Reset mid-refill: FSM returns to IDLE immediately, the partial line stays invalid, and `cache_inst_req` drops asynchronously. The bridge is reset by the same `rst`.

## Configuration
- `I_CACHE_KSEG1_BYPASS_EN` defined:
  - Addresses with addr[31:29]==3'b101 miss unconditionally in LOOKUP and go to UNCACHED.
  - UNCACHED: one downstream read of `{req_addr[31:2],2'b00}`, using the same REQ/WAIT handshake rules.
  - The returned word goes to `resp_word`, then RESP. Arrays are untouched.
  - Latency with zero-wait downstream: `data_ok` at T+4.
- Undefined: no UNCACHED state; kseg1 addresses are cached like any other address.

## Test plan
- Reset, then read 0xBFC00004 (zero-wait memory, word k = 0x1000+k) → downstream reads 0xBFC00000/04/08/0C, `cpu_inst_data_ok` at T+10 with 0x1001. With bypass defined: single read of 0xBFC00004 and `data_ok` at T+4.
- Read 0x00001008 twice → first is a miss; second returns 0x1002 at T+1 with no `cache_inst_req`.
- Read 0x00001000, then 0x00003000 (same index at INDEX_WIDTH=7) → second refills and evicts the first. Re-reading 0x00001000 misses again.
- Downstream `addr_ok` delayed 3 cycles per request → `cache_inst_addr` and `cache_inst_req` held stable across the stall. Final `cpu_inst_rdata` is correct.
- Assert `rst` after the second refill word → `cache_inst_req` drops at once. Re-reading the same line performs a full 4-word refill.
- Back-to-back `cpu_inst_req` held high over 8 hit addresses → `addr_ok` pulses every 2 cycles, with 8 `data_ok` pulses in order.

Source files
------------

// File: rtl/i_cache.sv
// ---------------------------------------------------------------------------
// i_cache
//
// Direct-mapped, read-only instruction cache between the CPU sram-like
// instruction port and the sram-like-to-AXI bridge. Hits are answered one
// cycle after acceptance. A miss refills the whole 16-byte line by issuing
// four sequential single-word reads downstream (word 0..3), then answers.
// Only one request is in flight on each side at any time.
//
// Parameters:
//   INDEX_WIDTH  line index bits (2^INDEX_WIDTH lines), tag = 28-INDEX_WIDTH
//
// Optional feature (compile-time macro):
//   I_CACHE_KSEG1_BYPASS_EN  when defined, addresses with addr[31:29]==3'b101
//                            bypass the arrays with one single-word read.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cpu_inst_req/wr/size/addr/wdata     CPU request (wr/size/wdata ignored)
//   cpu_inst_addr_ok                    request accepted this cycle
//   cpu_inst_data_ok/rdata              instruction word returned
//   cache_inst_req/wr/size/addr/wdata   downstream read request
//   cache_inst_addr_ok                  downstream accepted request
//   cache_inst_data_ok/rdata            downstream read data
// ---------------------------------------------------------------------------
module i_cache #(
  parameter int INDEX_WIDTH = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_inst_req,
  input  logic        cpu_inst_wr,
  input  logic [1:0]  cpu_inst_size,
  input  logic [31:0] cpu_inst_addr,
  input  logic [31:0] cpu_inst_wdata,
  output logic        cpu_inst_addr_ok,
  output logic        cpu_inst_data_ok,
  output logic [31:0] cpu_inst_rdata,
  output logic        cache_inst_req,
  output logic        cache_inst_wr,
  output logic [1:0]  cache_inst_size,
  output logic [31:0] cache_inst_addr,
  output logic [31:0] cache_inst_wdata,
  input  logic        cache_inst_addr_ok,
  input  logic        cache_inst_data_ok,
  input  logic [31:0] cache_inst_rdata
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = 28 - INDEX_WIDTH;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOOKUP   = 3'd1;
  localparam logic [2:0] S_REQ      = 3'd2;
  localparam logic [2:0] S_WAIT     = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;
`ifdef I_CACHE_KSEG1_BYPASS_EN
  localparam logic [2:0] S_UNC_REQ  = 3'd5;
  localparam logic [2:0] S_UNC_WAIT = 3'd6;
`endif

  logic [2:0]             state;
  logic [2:0]             state_next;
  logic [31:0]            req_addr;
  logic [1:0]             cnt;
  logic [31:0]            resp_word;

  logic [LINES-1:0]       valid;
  logic [TAG_W-1:0]       tag_mem  [LINES];
  logic [31:0]            data_mem [LINES][4];

  logic [INDEX_WIDTH-1:0] idx;
  logic [TAG_W-1:0]       req_tag;
  logic                   hit;
  logic                   bypass;
  logic                   lookup_hit;
  logic                   lookup_miss;
  logic                   fill_beat;
  logic                   last_beat;

  assign idx     = req_addr[INDEX_WIDTH+3:4];
  assign req_tag = req_addr[31:INDEX_WIDTH+4];
  assign hit     = valid[idx] && (tag_mem[idx] == req_tag);

`ifdef I_CACHE_KSEG1_BYPASS_EN
  logic unc_beat;
  assign bypass   = (req_addr[31:29] == 3'b101);
  // A word arrives either in the wait state or together with the accept.
  assign unc_beat = ((state == S_UNC_WAIT) && cache_inst_data_ok) ||
                    ((state == S_UNC_REQ) && cache_inst_addr_ok && cache_inst_data_ok);
`else
  assign bypass = 1'b0;
`endif

  assign lookup_hit  = (state == S_LOOKUP) && hit && !bypass;
  assign lookup_miss = (state == S_LOOKUP) && !hit && !bypass;

  // Data may come back in the same cycle the bridge accepts the request, in
  // which case the word is consumed straight from REQ and WAIT is skipped.
  assign fill_beat = ((state == S_WAIT) && cache_inst_data_ok) ||
                     ((state == S_REQ) && cache_inst_addr_ok && cache_inst_data_ok);
  assign last_beat = fill_beat && (cnt == 2'd3);

  wire unused_inputs = &{1'b0, cpu_inst_wr, cpu_inst_size, cpu_inst_wdata, req_addr[1:0]};

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (cpu_inst_req) state_next = S_LOOKUP;
      end
      S_LOOKUP: begin
`ifdef I_CACHE_KSEG1_BYPASS_EN
        if (bypass)      state_next = S_UNC_REQ;
        else
`endif
        if (hit)         state_next = S_IDLE;
        else             state_next = S_REQ;
      end
      S_REQ: begin
        if (cache_inst_addr_ok) begin
          if (cache_inst_data_ok) state_next = (cnt == 2'd3) ? S_RESP : S_REQ;
          else                    state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cache_inst_data_ok) state_next = (cnt == 2'd3) ? S_RESP : S_REQ;
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
`ifdef I_CACHE_KSEG1_BYPASS_EN
      S_UNC_REQ: begin
        if (cache_inst_addr_ok) state_next = cache_inst_data_ok ? S_RESP : S_UNC_WAIT;
      end
      S_UNC_WAIT: begin
        if (cache_inst_data_ok) state_next = S_RESP;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Control state. The victim line is invalidated as soon as the miss is
  // detected, so an interrupted refill never leaves a half-written line
  // looking valid; it becomes valid again only with the fourth word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      req_addr  <= '0;
      cnt       <= 2'd0;
      resp_word <= '0;
      valid     <= '0;
    end else begin
      state <= state_next;
      if ((state == S_IDLE) && cpu_inst_req) req_addr <= cpu_inst_addr;
      if (lookup_miss) begin
        cnt        <= 2'd0;
        valid[idx] <= 1'b0;
      end
      if (fill_beat) begin
        if (cnt == req_addr[3:2]) resp_word <= cache_inst_rdata;
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) valid[idx] <= 1'b1;
      end
`ifdef I_CACHE_KSEG1_BYPASS_EN
      if (unc_beat) resp_word <= cache_inst_rdata;
`endif
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_beat) data_mem[idx][cnt] <= cache_inst_rdata;
    if (last_beat) tag_mem[idx] <= req_tag;
  end

  always_comb begin
    cpu_inst_addr_ok = (state == S_IDLE) && cpu_inst_req;
    cpu_inst_data_ok = lookup_hit || (state == S_RESP);
    cpu_inst_rdata   = '0;
    if (state == S_RESP)  cpu_inst_rdata = resp_word;
    else if (lookup_hit)  cpu_inst_rdata = data_mem[idx][req_addr[3:2]];

    cache_inst_req   = 1'b0;
    cache_inst_addr  = '0;
    if (state == S_REQ) begin
      cache_inst_req  = 1'b1;
      cache_inst_addr = {req_addr[31:4], cnt, 2'b00};
    end
`ifdef I_CACHE_KSEG1_BYPASS_EN
    if (state == S_UNC_REQ) begin
      cache_inst_req  = 1'b1;
      cache_inst_addr = {req_addr[31:2], 2'b00};
    end
`endif
  end

  assign cache_inst_wr    = 1'b0;
  assign cache_inst_size  = 2'b10;
  assign cache_inst_wdata = '0;

endmodule
